// File: rtl/down_timer.sv
// ----------------------------------------------------------------------------
// down_timer
//   Loadable down-counting timer with a one-cycle terminal-count pulse.
//   A load captures the start value and mode and starts the timer.
//   Each count_enable strobe while running moves the count down by one.
//   The enabled edge that sees count==0 is the expiry edge. It raises tc,
//   then either reloads the count (periodic mode) or stops the timer
//   (one-shot mode). An interval is therefore load_value+1 enabled edges.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   load         load strobe: captures load_value and mode, starts timer
//   load_value   start / reload value (WIDTH bits)
//   mode         sampled on load: 0 = one-shot, 1 = periodic
//   count_enable advance strobe
//   count        current count (registered)
//   tc           terminal-count pulse, one clk wide (registered)
//   busy         high while the timer is running (registered)
// ----------------------------------------------------------------------------
module down_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  // An expiry happens only on an enabled edge in RUN that sees zero and
  // has no load competing with it. A load always wins.
  logic expire;
  assign expire = (state_q == RUN) && count_enable && (count_q == '0) && !load;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (load)                 state_d = RUN;
    else if (expire && !mode_q) state_d = IDLE;
  end

  // Datapath next-state / output logic.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      mode_d   = mode;
    end else if (expire) begin
      tc_d = 1'b1;
      // One-shot leaves count parked at zero; periodic starts a new interval.
      if (mode_q) count_d = reload_q;
    end else if (state_q == RUN && count_enable) begin
      // count is non-zero here, so the decrement cannot wrap.
      count_d = count_q - 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         mode;
  logic         count_enable;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  int checks = 0;
  int errors = 0;

  down_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .mode(mode), .count_enable(count_enable),
    .count(count), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model in terms of "enabled edges left until expiry".
  // While running, the visible count is that number minus one.
  bit m_run, m_per, m_tc;
  int m_left, m_rel;

  function automatic int m_count();
    return m_run ? m_left - 1 : 0;
  endfunction

  task automatic m_reset();
    m_run = 0; m_per = 0; m_tc = 0; m_left = 1; m_rel = 0;
  endtask

  task automatic m_edge(input bit ld, input int lv, input bit md, input bit en);
    m_tc = 0;
    if (ld) begin
      m_run = 1; m_per = md; m_rel = lv; m_left = lv + 1;
    end else if (m_run && en) begin
      m_left--;
      if (m_left == 0) begin
        m_tc = 1;
        if (m_per) m_left = m_rel + 1;
        else begin m_run = 0; m_left = 1; end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " count"}, int'(count), m_count());
    chk({tag, " tc"},    int'(tc),    int'(m_tc));
    chk({tag, " busy"},  int'(busy),  int'(m_run));
  endtask

  // Drive one edge's worth of inputs, clock, then compare against the model.
  task automatic step(input bit ld, input int lv, input bit md, input bit en,
                      input string tag);
    load = ld; load_value = W'(lv); mode = md; count_enable = en;
    @(posedge clk);
    m_edge(ld, lv, md, en);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    bit ld; int lv; bit md; bit en;
    int e_cnt; bit e_tc; bit e_busy;
  } vec_t;

  vec_t tv[$];

  initial begin
    // Directed vectors applied from a clean reset.
    tv.push_back('{0, 0, 0, 1,  0, 0, 0}); // idle ignores enable
    tv.push_back('{1, 5, 0, 1,  5, 0, 1}); // load one-shot 5
    tv.push_back('{0, 0, 0, 1,  4, 0, 1});
    tv.push_back('{0, 0, 0, 1,  3, 0, 1});
    tv.push_back('{0, 0, 0, 1,  2, 0, 1});
    tv.push_back('{0, 0, 0, 0,  2, 0, 1}); // disabled holds
    tv.push_back('{0, 0, 0, 1,  1, 0, 1});
    tv.push_back('{0, 0, 0, 1,  0, 0, 1});
    tv.push_back('{0, 0, 0, 1,  0, 1, 0}); // expiry, busy falls with tc
    tv.push_back('{0, 0, 0, 1,  0, 0, 0});
    tv.push_back('{1, 3, 1, 0,  3, 0, 1}); // periodic 3
    tv.push_back('{0, 0, 0, 1,  2, 0, 1});
    tv.push_back('{0, 0, 0, 0,  2, 0, 1});
    tv.push_back('{0, 0, 0, 1,  1, 0, 1});
    tv.push_back('{0, 0, 0, 0,  1, 0, 1});
    tv.push_back('{0, 0, 0, 1,  0, 0, 1});
    tv.push_back('{0, 0, 0, 0,  0, 0, 1});
    tv.push_back('{0, 0, 0, 1,  3, 1, 1}); // reload with tc
    tv.push_back('{0, 0, 0, 0,  3, 0, 1});
    tv.push_back('{0, 0, 0, 1,  2, 0, 1});
    tv.push_back('{0, 0, 0, 1,  1, 0, 1});
    tv.push_back('{0, 0, 0, 1,  0, 0, 1});
    tv.push_back('{1, 9, 0, 1,  9, 0, 1}); // load on expiry edge wins
    tv.push_back('{0, 0, 0, 1,  8, 0, 1});
    tv.push_back('{1, 0, 1, 1,  0, 0, 1}); // periodic 0
    tv.push_back('{0, 0, 0, 1,  0, 1, 1});
    tv.push_back('{0, 0, 0, 1,  0, 1, 1});
    tv.push_back('{0, 0, 0, 0,  0, 0, 1});
    tv.push_back('{0, 0, 0, 1,  0, 1, 1});

    load = 0; load_value = '0; mode = 0; count_enable = 0;
    reset = 0;
    m_reset();
    #12;
    chk_model("reset");
    chk("reset count", int'(count), 0);
    chk("reset busy", int'(busy), 0);
    @(negedge clk);
    reset = 1;

    foreach (tv[i]) begin
      step(tv[i].ld, tv[i].lv, tv[i].md, tv[i].en, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl count", i), int'(count), tv[i].e_cnt);
      chk($sformatf("vec%0d tbl tc", i),    int'(tc),    int'(tv[i].e_tc));
      chk($sformatf("vec%0d tbl busy", i),  int'(busy),  int'(tv[i].e_busy));
    end

    // Asynchronous reset mid-run at count 17.
    step(1, 20, 0, 0, "rst load");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "rst run");
    chk("pre-reset count", int'(count), 17);
    #2 reset = 0;
    m_reset();
    #1;
    chk("async reset count", int'(count), 0);
    chk("async reset tc", int'(tc), 0);
    chk("async reset busy", int'(busy), 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, "post-reset idle");
      chk("post-reset count", int'(count), 0);
      chk("post-reset tc", int'(tc), 0);
    end

    // Max value, periodic: 64 enabled edges per interval.
    step(1, 63, 1, 0, "max load");
    for (int i = 0; i < 63; i++) step(0, 0, 0, 1, "max run");
    chk("max pre-expiry count", int'(count), 0);
    chk("max pre-expiry tc", int'(tc), 0);
    step(0, 0, 0, 1, "max expiry");
    chk("max expiry tc", int'(tc), 1);
    chk("max reload count", int'(count), 63);
    chk("max busy", int'(busy), 1);

    // Load mid-count restarts from the new value.
    step(1, 30, 0, 0, "mid load");
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, "mid run");
    chk("mid count", int'(count), 12);
    step(1, 40, 0, 1, "mid reload");
    chk("mid reload count", int'(count), 40);
    chk("mid reload tc", int'(tc), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit ld, md, en;
      int lv;
      ld = ($urandom_range(0, 15) == 0);
      md = $urandom_range(0, 1);
      en = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
      step(ld, lv, md, en, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
